// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants and the next-PC select encoding.
// The decode stage imports the same constants so both stages agree on
// datapath width, reset vector and the bubble encoding.
package fetch_stage_pkg;

    localparam int          WIDTH     = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

    // Source of the next program counter value.
    typedef enum logic [1:0] {
        PC_SEL_SEQ      = 2'd0,
        PC_SEL_HOLD     = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. A bubble (squash) overrides a hold, and a hold
// overrides a capture, so a redirect or flush always discards the
// wrong-path word even when the hazard unit is stalling.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int                WIDTH     = fetch_stage_pkg::WIDTH,
    parameter logic [WIDTH-1:0]  NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] pc4_in,
    input  logic [WIDTH-1:0] instr_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic [WIDTH-1:0] instr,
    output logic             valid
);

    // Bubble beats hold beats capture; reset clears to an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            pc4   <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (bubble) begin
            pc    <= '0;
            pc4   <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!hold) begin
            pc    <= pc_in;
            pc4   <= pc4_in;
            instr <= instr_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address directly from the PC register and feeds the IF/ID register.
// Optional build macro FETCH_ALIGN_CHECK_EN: word-aligns redirect targets
// and exposes a sticky fetch_misalign flag.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                WIDTH     = fetch_stage_pkg::WIDTH,
    parameter logic [WIDTH-1:0]  RESET_PC  = fetch_stage_pkg::RESET_PC,
    parameter logic [WIDTH-1:0]  NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic             fetch_misalign,
`endif
    output logic [WIDTH-1:0] ifid_pc,
    output logic [WIDTH-1:0] ifid_pc4,
    output logic [WIDTH-1:0] ifid_instr,
    output logic             ifid_valid
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] target_eff;
    pc_sel_e          pc_sel;

    // The memory sees the PC register with no logic in between.
    assign imem_addr = pc;

    // Sequential fetch address; wraps naturally at 2^WIDTH.
    assign pc_inc = pc + WIDTH'(PC_STEP);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_eff = {branch_target[WIDTH-1:2], 2'b00};
`else
    assign target_eff = branch_target;
`endif

    // Redirect has priority over stall so a stalled wrong path is dropped.
    always_comb begin
        pc_sel = PC_SEL_SEQ;
        if (branch_taken) begin
            pc_sel = PC_SEL_REDIRECT;
        end else if (stall) begin
            pc_sel = PC_SEL_HOLD;
        end
    end

    // Next-PC mux driven by the select above.
    always_comb begin
        pc_next = pc_inc;
        unique case (pc_sel)
            PC_SEL_REDIRECT: pc_next = target_eff;
            PC_SEL_HOLD:     pc_next = pc;
            default:         pc_next = pc_inc;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky flag: remembers any redirect that arrived with low bits set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_misalign <= 1'b0;
        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            fetch_misalign <= 1'b1;
        end
    end
`endif

    // A taken branch squashes the word fetched this cycle, same as a flush.
    ifid_reg #(
        .WIDTH     (WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (stall),
        .bubble   (flush | branch_taken),
        .pc_in    (pc),
        .pc4_in   (pc_inc),
        .instr_in (imem_data),
        .pc       (ifid_pc),
        .pc4      (ifid_pc4),
        .instr    (ifid_instr),
        .valid    (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset and wrap
// sequences, then randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         branch_taken = 1'b0;
    logic [W-1:0] branch_target = '0;
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_data;
    logic [W-1:0] ifid_pc;
    logic [W-1:0] ifid_pc4;
    logic [W-1:0] ifid_instr;
    logic         ifid_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         fetch_misalign;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .ifid_pc       (ifid_pc),
        .ifid_pc4      (ifid_pc4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid)
    );

    always #5 clk = ~clk;

    // Memory image: word i holds 0x1000_0000 + i.
    function automatic logic [W-1:0] word_at(input logic [W-1:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign imem_data = word_at(imem_addr);

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model state.
    logic [W-1:0] m_pc;
    logic [W-1:0] m_ipc;
    logic [W-1:0] m_instr;
    logic         m_valid;
    logic         m_mis;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_ipc   = 32'h0;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic b, input logic [W-1:0] t);
        logic [W-1:0] tgt;
        tgt = t;
`ifdef FETCH_ALIGN_CHECK_EN
        if (b && (t % 4 != 0)) begin
            tgt   = t - (t % 4);
            m_mis = 1'b1;
        end
`endif
        if (b || f) begin
            m_ipc   = 32'h0;
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (!s) begin
            m_ipc   = m_pc;
            m_instr = word_at(m_pc);
            m_valid = 1'b1;
        end
        if (b)       m_pc = tgt;
        else if (!s) m_pc = m_pc + 32'd4;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".addr"},  imem_addr, m_pc);
        chk({tag, ".ipc"},   ifid_pc, m_ipc);
        chk({tag, ".ipc4"},  ifid_pc4, m_valid ? m_ipc + 32'd4 : 32'h0);
        chk({tag, ".instr"}, ifid_instr, m_instr);
        chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
`ifdef FETCH_ALIGN_CHECK_EN
        chk({tag, ".mis"},   {31'b0, fetch_misalign}, {31'b0, m_mis});
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".addr"},  imem_addr, 32'h0);
        chk({tag, ".ipc"},   ifid_pc, 32'h0);
        chk({tag, ".ipc4"},  ifid_pc4, 32'h0);
        chk({tag, ".instr"}, ifid_instr, 32'h0);
        chk({tag, ".valid"}, {31'b0, ifid_valid}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk({tag, ".mis"},   {31'b0, fetch_misalign}, 32'h0);
`endif
    endtask

    // Drive inputs, take one rising edge, settle 1 time unit past it.
    task automatic apply(input logic s, input logic f, input logic b, input logic [W-1:0] t);
        stall = s;
        flush = f;
        branch_taken = b;
        branch_target = t;
        model_edge(s, f, b, t);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         s;
        logic         f;
        logic         b;
        logic [W-1:0] tgt;
        logic [W-1:0] e_addr;
        logic [W-1:0] e_ipc;
        logic [W-1:0] e_instr;
        logic         e_valid;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin
        vecs[0]  = '{0, 0, 0, 32'h0,  32'h04, 32'h00, 32'h1000_0000, 1};
        vecs[1]  = '{0, 0, 0, 32'h0,  32'h08, 32'h04, 32'h1000_0001, 1};
        vecs[2]  = '{1, 0, 0, 32'h0,  32'h08, 32'h04, 32'h1000_0001, 1};
        vecs[3]  = '{1, 0, 0, 32'h0,  32'h08, 32'h04, 32'h1000_0001, 1};
        vecs[4]  = '{1, 0, 0, 32'h0,  32'h08, 32'h04, 32'h1000_0001, 1};
        vecs[5]  = '{0, 0, 0, 32'h0,  32'h0C, 32'h08, 32'h1000_0002, 1};
        vecs[6]  = '{0, 0, 1, 32'h40, 32'h40, 32'h00, 32'h0000_0000, 0};
        vecs[7]  = '{0, 0, 0, 32'h0,  32'h44, 32'h40, 32'h1000_0010, 1};
        vecs[8]  = '{1, 0, 1, 32'h80, 32'h80, 32'h00, 32'h0000_0000, 0};
        vecs[9]  = '{0, 0, 0, 32'h0,  32'h84, 32'h80, 32'h1000_0020, 1};
        vecs[10] = '{1, 1, 0, 32'h0,  32'h84, 32'h00, 32'h0000_0000, 0};
        vecs[11] = '{0, 1, 0, 32'h0,  32'h88, 32'h00, 32'h0000_0000, 0};
        vecs[12] = '{0, 0, 0, 32'h0,  32'h8C, 32'h88, 32'h1000_0022, 1};
        vecs[13] = '{1, 0, 0, 32'h0,  32'h8C, 32'h88, 32'h1000_0022, 1};
`ifdef FETCH_ALIGN_CHECK_EN
        vecs[14] = '{0, 0, 1, 32'h46, 32'h44, 32'h00, 32'h0000_0000, 0};
        vecs[15] = '{0, 0, 0, 32'h0,  32'h48, 32'h44, 32'h1000_0011, 1};
`else
        vecs[14] = '{0, 0, 1, 32'h46, 32'h46, 32'h00, 32'h0000_0000, 0};
        vecs[15] = '{0, 0, 0, 32'h0,  32'h4A, 32'h46, 32'h1000_0011, 1};
`endif

        // Reset state while rst_n is held low.
        model_reset();
        #12;
        check_reset_vals("rst");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(vecs[i].s, vecs[i].f, vecs[i].b, vecs[i].tgt);
            chk({tag, ".addr"},  imem_addr, vecs[i].e_addr);
            chk({tag, ".ipc"},   ifid_pc, vecs[i].e_ipc);
            chk({tag, ".ipc4"},  ifid_pc4, vecs[i].e_valid ? vecs[i].e_ipc + 32'd4 : 32'h0);
            chk({tag, ".instr"}, ifid_instr, vecs[i].e_instr);
            chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, vecs[i].e_valid});
`ifdef FETCH_ALIGN_CHECK_EN
            chk({tag, ".mis"}, {31'b0, fetch_misalign}, (i >= 14) ? 32'h1 : 32'h0);
`endif
        end

        // Sticky flag must survive more traffic, including aligned branches.
        apply(1'b0, 1'b0, 1'b1, 32'h100);
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        check_model("sticky");

        // Async reset between edges, with stall/branch asserted.
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h200;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        check_model("post_rst");
        chk("post_rst.first", ifid_pc, 32'h0);

        // PC wrap at the top of the address space.
        apply(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check_model("wrap0");
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        check_model("wrap1");
        chk("wrap.addr", imem_addr, 32'h0);
        chk("wrap.ipc4", ifid_pc4, 32'h0);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 400; n++) begin
            logic         s, f, b;
            logic [W-1:0] t;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            apply(s, f, b, t);
            check_model($sformatf("rnd%0d", n));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_reset_vals($sformatf("rnd_rst%0d", n));
                #1;
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
